// File: rtl/port_alloc_if.sv
// Router switch-allocation bundle: per-input-VC requests, routing and
// downstream credit status in; buffer read grants, crossbar selects and
// per-output flit-valid out.
interface port_alloc_if #(
    parameter int PORT_NUM = 5,
    parameter int VC_NUM   = 2
);
    localparam int PORT_W = $clog2(PORT_NUM);
    localparam int VC_W   = $clog2(VC_NUM);

    logic [PORT_NUM-1:0][VC_NUM-1:0]             req_i;
    logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_W-1:0] out_port_i;
    logic [PORT_NUM-1:0][VC_NUM-1:0][VC_W-1:0]   down_vc_i;
    logic [PORT_NUM-1:0][VC_NUM-1:0]             on_off_i;
    logic [PORT_NUM-1:0][VC_NUM-1:0]             grant_o;
    logic [PORT_NUM-1:0][PORT_W-1:0]             xbar_sel_o;
    logic [PORT_NUM-1:0]                         valid_flit_o;

    modport master (
        output req_i, out_port_i, down_vc_i, on_off_i,
        input  grant_o, xbar_sel_o, valid_flit_o
    );

    modport slave (
        input  req_i, out_port_i, down_vc_i, on_off_i,
        output grant_o, xbar_sel_o, valid_flit_o
    );
endinterface

// File: rtl/port_alloc_scheduler.sv
// Two-stage separable switch allocator. Stage 1 picks one eligible VC per
// input port (round-robin), stage 2 picks one input per output port
// (round-robin). Grants are combinational; crossbar select and flit-valid
// are registered one cycle later. Pointers only advance on a real grant.
module port_alloc_scheduler #(
    parameter int PORT_NUM = 5,
    parameter int VC_NUM   = 2
) (
    input  logic          clk,
    input  logic          rst,
    port_alloc_if.slave   bus
);
    localparam int PORT_W = $clog2(PORT_NUM);
    localparam int VC_W   = $clog2(VC_NUM);

    logic [PORT_NUM-1:0][VC_W-1:0]   in_ptr;
    logic [PORT_NUM-1:0][PORT_W-1:0] out_ptr;
    logic [PORT_NUM-1:0][VC_NUM-1:0] elig;
    logic [PORT_NUM-1:0]             s1_vld;
    logic [PORT_NUM-1:0][VC_W-1:0]   s1_vc;
    logic [PORT_NUM-1:0][PORT_W-1:0] s1_port;
    logic [PORT_NUM-1:0]             s2_vld;
    logic [PORT_NUM-1:0][PORT_W-1:0] s2_src;

    // A VC is eligible only with a legal output port and an "on" downstream VC.
    always_comb begin
        elig = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (bus.req_i[i][v] &&
                    (int'(bus.out_port_i[i][v]) < PORT_NUM) &&
                    (int'(bus.down_vc_i[i][v]) < VC_NUM)) begin
                    elig[i][v] = bus.on_off_i[bus.out_port_i[i][v]][bus.down_vc_i[i][v]];
                end
            end
        end
    end

    // Stage 1: per input port, first eligible VC starting at in_ptr.
    always_comb begin
        s1_vld  = '0;
        s1_vc   = '0;
        s1_port = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int k = 0; k < VC_NUM; k++) begin
                int v;
                v = (int'(in_ptr[i]) + k) % VC_NUM;
                if (!s1_vld[i] && elig[i][v]) begin
                    s1_vld[i]  = 1'b1;
                    s1_vc[i]   = VC_W'(v);
                    s1_port[i] = bus.out_port_i[i][v];
                end
            end
        end
    end

    // Stage 2: per output port, first stage-1 winner starting at out_ptr.
    always_comb begin
        s2_vld = '0;
        s2_src = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int k = 0; k < PORT_NUM; k++) begin
                int i;
                i = (int'(out_ptr[o]) + k) % PORT_NUM;
                if (!s2_vld[o] && s1_vld[i] && (int'(s1_port[i]) == o)) begin
                    s2_vld[o] = 1'b1;
                    s2_src[o] = PORT_W'(i);
                end
            end
        end
    end

    // Buffer read enables; each input targets one output so it gets at most one grant.
    always_comb begin
        bus.grant_o = '0;
        if (!rst) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (s2_vld[o]) begin
                    bus.grant_o[s2_src[o]][s1_vc[s2_src[o]]] = 1'b1;
                end
            end
        end
    end

    // Pointer advance past each winner, and registered crossbar control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ptr           <= '0;
            out_ptr          <= '0;
            bus.valid_flit_o <= '0;
            bus.xbar_sel_o   <= '0;
        end else begin
            bus.valid_flit_o <= s2_vld;
            for (int o = 0; o < PORT_NUM; o++) begin
                if (s2_vld[o]) begin
                    bus.xbar_sel_o[o]  <= s2_src[o];
                    out_ptr[o]         <= PORT_W'((int'(s2_src[o]) + 1) % PORT_NUM);
                    in_ptr[s2_src[o]]  <= VC_W'((int'(s1_vc[s2_src[o]]) + 1) % VC_NUM);
                end
            end
        end
    end
endmodule

// File: tb/tb_port_alloc_scheduler.sv
// Bench for port_alloc_scheduler: each scenario drives requests, checks the
// combinational grant against a hand-derived value, and pushes the expected
// registered crossbar state into a queue that is popped after the next edge.
module tb_port_alloc_scheduler;
    localparam int P  = 5;
    localparam int V  = 2;
    localparam int PW = 3;

    typedef logic [P-1:0][V-1:0]  gmat_t;
    typedef logic [P-1:0][PW-1:0] sel_t;
    typedef struct {
        logic [P-1:0] vld;
        sel_t         sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    port_alloc_if #(.PORT_NUM(P), .VC_NUM(V)) bus ();

    port_alloc_scheduler #(.PORT_NUM(P), .VC_NUM(V)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t sb_q[$];
    sel_t sb_sel;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic clear_inputs();
        bus.req_i      = '0;
        bus.out_port_i = '0;
        bus.down_vc_i  = '0;
        bus.on_off_i   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        sb_q.delete();
        sb_sel = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Registered outputs implied by an expected grant pattern.
    task automatic push_exp(input gmat_t g);
        exp_t e;
        e.vld = '0;
        for (int i = 0; i < P; i++) begin
            for (int v = 0; v < V; v++) begin
                if (g[i][v]) begin
                    e.vld[bus.out_port_i[i][v]]  = 1'b1;
                    sb_sel[bus.out_port_i[i][v]] = PW'(i);
                end
            end
        end
        e.sel = sb_sel;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        gmat_t eg;
        exp_t  e;
        int    win[2] = '{0, 1};
        rst = 1'b1;
        clear_inputs();
        sb_sel = '0;
        bus.req_i[0][0] = 1'b1; bus.out_port_i[0][0] = 3'd1;
        bus.req_i[1][0] = 1'b1; bus.out_port_i[1][0] = 3'd1;
        bus.on_off_i = '1;
        #1;
        n_checks++; if (bus.grant_o !== '0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", bus.grant_o); end
        n_checks++; if (bus.valid_flit_o !== '0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid_flit_o); end
        n_checks++; if (bus.xbar_sel_o !== '0) begin n_fail++; $display("FAIL reset_sel: got %h want 0", bus.xbar_sel_o); end
        @(posedge clk); #1;
        n_checks++; if (bus.grant_o !== '0) begin n_fail++; $display("FAIL reset_held_grant: got %b want 0", bus.grant_o); end
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #2;
            eg = '0; eg[win[c]][0] = 1'b1;
            n_checks++; if (bus.grant_o !== eg) begin n_fail++; $display("FAIL post_reset_grant c%0d: got %b want %b", c, bus.grant_o, eg); end
            push_exp(eg);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++; if (bus.valid_flit_o !== e.vld) begin n_fail++; $display("FAIL post_reset_valid c%0d: got %b want %b", c, bus.valid_flit_o, e.vld); end
            n_checks++; if (bus.xbar_sel_o !== e.sel) begin n_fail++; $display("FAIL post_reset_sel c%0d: got %h want %h", c, bus.xbar_sel_o, e.sel); end
        end
    endtask

    task automatic test_single();
        gmat_t eg;
        exp_t  e;
        do_reset();
        bus.req_i[1][0] = 1'b1; bus.out_port_i[1][0] = 3'd3; bus.down_vc_i[1][0] = 1'b0;
        bus.on_off_i[3][0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) bus.req_i = '0;
            #2;
            eg = '0; if (c < 2) eg[1] = 2'b01;
            n_checks++; if (bus.grant_o !== eg) begin n_fail++; $display("FAIL single_grant c%0d: got %b want %b", c, bus.grant_o, eg); end
            push_exp(eg);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++; if (bus.valid_flit_o !== e.vld) begin n_fail++; $display("FAIL single_valid c%0d: got %b want %b", c, bus.valid_flit_o, e.vld); end
            n_checks++; if (bus.xbar_sel_o !== e.sel) begin n_fail++; $display("FAIL single_sel c%0d: got %h want %h", c, bus.xbar_sel_o, e.sel); end
        end
    endtask

    task automatic test_rotate();
        gmat_t eg;
        exp_t  e;
        int    win[6] = '{0, 2, 4, 0, 2, 4};
        do_reset();
        foreach (win[k]) begin
            bus.req_i[win[k]][0] = 1'b1;
            bus.out_port_i[win[k]][0] = 3'd1;
        end
        bus.on_off_i[1][0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #2;
            eg = '0; eg[win[c]][0] = 1'b1;
            n_checks++; if (bus.grant_o !== eg) begin n_fail++; $display("FAIL rotate_grant c%0d: got %b want %b", c, bus.grant_o, eg); end
            push_exp(eg);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++; if (bus.valid_flit_o !== e.vld) begin n_fail++; $display("FAIL rotate_valid c%0d: got %b want %b", c, bus.valid_flit_o, e.vld); end
            n_checks++; if (bus.xbar_sel_o !== e.sel) begin n_fail++; $display("FAIL rotate_sel c%0d: got %h want %h", c, bus.xbar_sel_o, e.sel); end
        end
    endtask

    task automatic test_vc_alternate();
        gmat_t eg;
        exp_t  e;
        do_reset();
        bus.req_i[2] = 2'b11;
        bus.out_port_i[2][0] = 3'd4; bus.down_vc_i[2][0] = 1'b0;
        bus.out_port_i[2][1] = 3'd4; bus.down_vc_i[2][1] = 1'b1;
        bus.on_off_i[4] = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #2;
            eg = '0; eg[2] = (c % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++; if (bus.grant_o !== eg) begin n_fail++; $display("FAIL vc_alt_grant c%0d: got %b want %b", c, bus.grant_o, eg); end
            push_exp(eg);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++; if (bus.valid_flit_o !== e.vld) begin n_fail++; $display("FAIL vc_alt_valid c%0d: got %b want %b", c, bus.valid_flit_o, e.vld); end
            n_checks++; if (bus.xbar_sel_o !== e.sel) begin n_fail++; $display("FAIL vc_alt_sel c%0d: got %h want %h", c, bus.xbar_sel_o, e.sel); end
        end
    endtask

    task automatic test_onoff_drop();
        gmat_t eg;
        exp_t  e;
        do_reset();
        bus.req_i[3][0] = 1'b1; bus.out_port_i[3][0] = 3'd2; bus.down_vc_i[3][0] = 1'b1;
        bus.on_off_i[2][1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) bus.on_off_i[2][1] = 1'b0;
            #2;
            eg = '0; if (c < 3) eg[3] = 2'b01;
            n_checks++; if (bus.grant_o !== eg) begin n_fail++; $display("FAIL onoff_grant c%0d: got %b want %b", c, bus.grant_o, eg); end
            push_exp(eg);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++; if (bus.valid_flit_o !== e.vld) begin n_fail++; $display("FAIL onoff_valid c%0d: got %b want %b", c, bus.valid_flit_o, e.vld); end
            n_checks++; if (bus.xbar_sel_o !== e.sel) begin n_fail++; $display("FAIL onoff_sel c%0d: got %h want %h", c, bus.xbar_sel_o, e.sel); end
        end
    endtask

    task automatic test_conflict();
        gmat_t eg;
        exp_t  e;
        do_reset();
        bus.req_i[0] = 2'b11;
        bus.out_port_i[0][0] = 3'd3;
        bus.out_port_i[0][1] = 3'd1;
        bus.req_i[1][0] = 1'b1; bus.out_port_i[1][0] = 3'd1;
        bus.on_off_i[3][0] = 1'b1;
        bus.on_off_i[1][0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            eg = '0;
            if (c % 2 == 0) begin eg[0] = 2'b01; eg[1] = 2'b01; end
            else            begin eg[0] = 2'b10; end
            n_checks++; if (bus.grant_o !== eg) begin n_fail++; $display("FAIL conflict_grant c%0d: got %b want %b", c, bus.grant_o, eg); end
            push_exp(eg);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++; if (bus.valid_flit_o !== e.vld) begin n_fail++; $display("FAIL conflict_valid c%0d: got %b want %b", c, bus.valid_flit_o, e.vld); end
            n_checks++; if (bus.xbar_sel_o !== e.sel) begin n_fail++; $display("FAIL conflict_sel c%0d: got %h want %h", c, bus.xbar_sel_o, e.sel); end
        end
    endtask

    task automatic test_edge_ports();
        gmat_t eg;
        exp_t  e;
        do_reset();
        bus.req_i[4] = 2'b11;
        bus.out_port_i[4][0] = 3'd5;
        bus.out_port_i[4][1] = 3'd7;
        bus.req_i[2][1] = 1'b1; bus.out_port_i[2][1] = 3'd2; bus.down_vc_i[2][1] = 1'b1;
        bus.on_off_i = '1;
        for (int c = 0; c < 2; c++) begin
            #2;
            eg = '0; eg[2] = 2'b10;
            n_checks++; if (bus.grant_o !== eg) begin n_fail++; $display("FAIL edge_grant c%0d: got %b want %b", c, bus.grant_o, eg); end
            push_exp(eg);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++; if (bus.valid_flit_o !== e.vld) begin n_fail++; $display("FAIL edge_valid c%0d: got %b want %b", c, bus.valid_flit_o, e.vld); end
            n_checks++; if (bus.xbar_sel_o !== e.sel) begin n_fail++; $display("FAIL edge_sel c%0d: got %h want %h", c, bus.xbar_sel_o, e.sel); end
        end
    endtask

    task automatic test_reset_midstream();
        gmat_t eg;
        exp_t  e;
        int    win[3] = '{1, 2, 1};
        do_reset();
        for (int i = 1; i < P; i++) begin
            bus.req_i[i][0] = 1'b1;
            bus.out_port_i[i][0] = 3'd2;
        end
        bus.on_off_i[2][0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                #2;
                rst = 1'b1;
                #1;
                n_checks++; if (bus.grant_o !== '0) begin n_fail++; $display("FAIL mid_reset_grant: got %b want 0", bus.grant_o); end
                n_checks++; if (bus.valid_flit_o !== '0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", bus.valid_flit_o); end
                n_checks++; if (bus.xbar_sel_o !== '0) begin n_fail++; $display("FAIL mid_reset_sel: got %h want 0", bus.xbar_sel_o); end
                sb_q.delete();
                sb_sel = '0;
                @(posedge clk); #1;
                rst = 1'b0;
            end
            #2;
            eg = '0; eg[win[c]][0] = 1'b1;
            n_checks++; if (bus.grant_o !== eg) begin n_fail++; $display("FAIL midstream_grant c%0d: got %b want %b", c, bus.grant_o, eg); end
            push_exp(eg);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++; if (bus.valid_flit_o !== e.vld) begin n_fail++; $display("FAIL midstream_valid c%0d: got %b want %b", c, bus.valid_flit_o, e.vld); end
            n_checks++; if (bus.xbar_sel_o !== e.sel) begin n_fail++; $display("FAIL midstream_sel c%0d: got %h want %h", c, bus.xbar_sel_o, e.sel); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_vc_alternate();
        test_onoff_drop();
        test_conflict();
        test_edge_ports();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
